// File: rtl/ceyloniac_pc_sequencer.sv
// Multi-cycle next-PC controller for the CEYLONIACX core.
// Steps fetch/decode/execute/update and drives ceyloniac_pc.
module ceyloniac_pc_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(32'h10)
) (
  input  logic                clk,
  input  logic                pc_seq_reset,
  input  logic [PC_WIDTH-1:0] pc_current,
  input  logic                fetch_ready,
  input  logic                exec_done,
  input  logic                instr_is_branch,
  input  logic                instr_is_jump,
  input  logic                instr_is_jr,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [PC_WIDTH-1:0] jr_target,
  input  logic                stall,
  input  logic                trap_req,
  output logic                pc_enable,
  output logic                pc_write,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                fetch_req,
  output logic                trap_ack,
  output logic [PC_WIDTH-1:0] epc,
  output logic [31:0]         retire_count,
  output logic [2:0]          seq_state
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_UPDATE  = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                rst_q, rst_d;
  logic [PC_WIDTH-1:0] seq_q, seq_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic [PC_WIDTH-1:0] off_q, off_d;
  logic [31:0]         retire_q, retire_d;
  logic                jr_q, jr_d;
  logic                br_q, br_d;

  always_comb begin
    state_d  = state_q;
    rst_d    = rst_q;
    seq_d    = seq_q;
    target_d = target_q;
    epc_d    = epc_q;
    off_d    = off_q;
    retire_d = retire_q;
    jr_d     = jr_q;
    br_d     = br_q;
    unique case (state_q)
      S_INIT: begin
        // first cycle after reset shows zeros, second loads the vector
        rst_d = 1'b0;
        if (!rst_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_ready) begin
          seq_d   = pc_current + PC_WIDTH'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        jr_d  = instr_is_jr;
        br_d  = instr_is_branch;
        off_d = branch_offset;
        if (instr_is_jr) begin
          state_d = S_EXECUTE;
        end else if (instr_is_jump) begin
          target_d = jump_target;
          state_d  = S_UPDATE;
        end else if (instr_is_branch) begin
          state_d = S_EXECUTE;
        end else begin
          target_d = seq_q;
          state_d  = S_UPDATE;
        end
      end
      S_EXECUTE: begin
        if (exec_done) begin
          if (jr_q)
            target_d = jr_target;
          else if (br_q && branch_taken)
            target_d = seq_q + off_q;
          else
            target_d = seq_q;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (!stall) begin
          if (trap_req) begin
            epc_d   = target_q;
            state_d = S_TRAP;
          end else begin
            retire_d = retire_q + 32'd1;
            state_d  = S_FETCH;
          end
        end
      end
      S_TRAP: state_d = S_FETCH;
      default: state_d = S_INIT;
    endcase
    if (pc_seq_reset) begin
      state_d  = S_INIT;
      rst_d    = 1'b1;
      seq_d    = '0;
      target_d = '0;
      epc_d    = '0;
      off_d    = '0;
      retire_d = '0;
      jr_d     = 1'b0;
      br_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    rst_q    <= rst_d;
    seq_q    <= seq_d;
    target_q <= target_d;
    epc_q    <= epc_d;
    off_q    <= off_d;
    retire_q <= retire_d;
    jr_q     <= jr_d;
    br_q     <= br_d;
  end

  always_comb begin
    pc_enable = !rst_q;
    pc_write  = 1'b0;
    pc_next   = target_q;
    fetch_req = 1'b0;
    trap_ack  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        pc_write = !rst_q;
        pc_next  = rst_q ? '0 : RESET_VECTOR;
      end
      S_FETCH:  fetch_req = 1'b1;
      S_UPDATE: pc_write = !stall && !trap_req;
      S_TRAP: begin
        pc_write = 1'b1;
        pc_next  = TRAP_VECTOR;
        trap_ack = 1'b1;
      end
      default: ;
    endcase
  end

  assign epc          = epc_q;
  assign retire_count = retire_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_ceyloniac_pc_sequencer.sv
// Bench for ceyloniac_pc_sequencer: instruction-level model
// plus a ceyloniac_pc stand-in closing the pc_current loop.
module tb_ceyloniac_pc_sequencer;

  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h10;

  logic        clk = 1'b0;
  logic        pc_seq_reset;
  logic [31:0] pc_current;
  logic        fetch_ready, exec_done;
  logic        instr_is_branch, instr_is_jump, instr_is_jr;
  logic        branch_taken;
  logic [31:0] branch_offset, jump_target, jr_target;
  logic        stall, trap_req;
  logic        pc_enable, pc_write, fetch_req, trap_ack;
  logic [31:0] pc_next, epc, retire_count;
  logic [2:0]  seq_state;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] pc_reg = 32'h0;
  logic [31:0] exp_pc, exp_retire, exp_epc;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (pc_enable && pc_write) pc_reg <= pc_next;

  assign pc_current = pc_reg;

  ceyloniac_pc_sequencer dut (
    .clk(clk), .pc_seq_reset(pc_seq_reset),
    .pc_current(pc_current), .fetch_ready(fetch_ready),
    .exec_done(exec_done),
    .instr_is_branch(instr_is_branch),
    .instr_is_jump(instr_is_jump),
    .instr_is_jr(instr_is_jr),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .jump_target(jump_target), .jr_target(jr_target),
    .stall(stall), .trap_req(trap_req),
    .pc_enable(pc_enable), .pc_write(pc_write),
    .pc_next(pc_next), .fetch_req(fetch_req),
    .trap_ack(trap_ack), .epc(epc),
    .retire_count(retire_count), .seq_state(seq_state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    instr_is_branch = 1'($urandom);
    instr_is_jump   = 1'($urandom);
    instr_is_jr     = 1'($urandom);
    branch_taken    = 1'($urandom);
    branch_offset   = $urandom;
    jump_target     = $urandom;
    jr_target       = $urandom;
  endtask

  // One instruction; the expected next PC comes from the ISA rules.
  task automatic do_instr(input bit j, input bit br, input bit jr,
                          input bit tk, input logic [31:0] off,
                          input logic [31:0] jt,
                          input logic [31:0] jrt,
                          input int fw, input int ew,
                          input int ns, input bit trap);
    logic [31:0] sq, nxt;
    bit exe;
    sq  = exp_pc + 32'd1;
    exe = jr || (br && !j);
    if (jr)            nxt = jrt;
    else if (j)        nxt = jt;
    else if (br && tk) nxt = sq + off;
    else               nxt = sq;
    for (int i = 0; i <= fw; i++) begin
      scramble();
      fetch_ready = (i == fw);
      exec_done   = 1'($urandom);
      stall       = 1'($urandom);
      trap_req    = 1'($urandom);
      #1;
      chk("fetch_state", 32'(seq_state), 1);
      chk("fetch_req", 32'(fetch_req), 1);
      chk("fetch_pc_write", 32'(pc_write), 0);
      chk("fetch_pc_enable", 32'(pc_enable), 1);
      tick();
    end
    fetch_ready     = 1'b0;
    instr_is_jump   = j;
    instr_is_branch = br;
    instr_is_jr     = jr;
    branch_offset   = off;
    jump_target     = jt;
    #1;
    chk("decode_state", 32'(seq_state), 2);
    chk("decode_pc_write", 32'(pc_write), 0);
    tick();
    if (exe) begin
      for (int i = 0; i <= ew; i++) begin
        scramble();
        exec_done = (i == ew);
        if (i == ew) begin
          branch_taken = tk;
          jr_target    = jrt;
        end
        #1;
        chk("exec_state", 32'(seq_state), 3);
        chk("exec_pc_write", 32'(pc_write), 0);
        tick();
      end
    end
    exec_done = 1'b0;
    for (int s = 0; s < ns; s++) begin
      scramble();
      stall    = 1'b1;
      trap_req = 1'($urandom);
      #1;
      chk("stall_state", 32'(seq_state), 4);
      chk("stall_pc_write", 32'(pc_write), 0);
      chk("stall_pc_next", pc_next, nxt);
      tick();
    end
    stall    = 1'b0;
    trap_req = trap;
    #1;
    chk("update_state", 32'(seq_state), 4);
    chk("update_pc_write", 32'(pc_write), 32'(!trap));
    chk("update_pc_next", pc_next, nxt);
    tick();
    trap_req = 1'b0;
    if (trap) begin
      exp_epc = nxt;
      #1;
      chk("trap_state", 32'(seq_state), 5);
      chk("trap_ack", 32'(trap_ack), 1);
      chk("trap_pc_write", 32'(pc_write), 1);
      chk("trap_pc_next", pc_next, TV);
      chk("trap_epc", epc, exp_epc);
      chk("trap_retire", retire_count, exp_retire);
      tick();
      exp_pc = TV;
      chk("post_trap_ack", 32'(trap_ack), 0);
    end else begin
      exp_retire = exp_retire + 32'd1;
      exp_pc     = nxt;
    end
    #1;
    chk("retire_count", retire_count, exp_retire);
    chk("epc_hold", epc, exp_epc);
    chk("pc_loaded", pc_current, exp_pc);
  endtask

  task automatic chk_reset_vals;
    chk("rst_state", 32'(seq_state), 0);
    chk("rst_pc_enable", 32'(pc_enable), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_pc_next", pc_next, 0);
    chk("rst_fetch_req", 32'(fetch_req), 0);
    chk("rst_trap_ack", 32'(trap_ack), 0);
    chk("rst_epc", epc, 0);
    chk("rst_retire", retire_count, 0);
  endtask

  task automatic chk_init_load;
    chk("init_state", 32'(seq_state), 0);
    chk("init_pc_write", 32'(pc_write), 1);
    chk("init_pc_enable", 32'(pc_enable), 1);
    chk("init_pc_next", pc_next, RV);
    tick();
    exp_pc = RV; exp_retire = 0; exp_epc = 0;
    chk("init_to_fetch", 32'(seq_state), 1);
    chk("init_pc_loaded", pc_current, exp_pc);
  endtask

  initial begin
    pc_seq_reset = 1'b1;
    fetch_ready = 0; exec_done = 0; stall = 0; trap_req = 0;
    instr_is_branch = 0; instr_is_jump = 0; instr_is_jr = 0;
    branch_taken = 0; branch_offset = 0;
    jump_target = 0; jr_target = 0;
    exp_pc = 0; exp_retire = 0; exp_epc = 0;
    tick(); tick(); tick();
    chk_reset_vals();
    pc_seq_reset = 1'b0;
    tick();
    chk_init_load();

    repeat (3) do_instr(0,0,0,0, 0,0,0, 0,0,0, 0);
    chk("three_retired", retire_count, 3);

    do_instr(1,0,0,0, 0,32'h5,0, 0,0,0, 0);
    do_instr(0,1,0,1, 32'hFFFF_FFFC,0,0, 0,0,0, 0);
    chk("branch_back", pc_current, 32'h2);
    do_instr(1,0,0,0, 0,32'h5,0, 1,0,0, 0);
    do_instr(0,1,0,0, 32'hFFFF_FFFC,0,0, 0,2,0, 0);
    chk("branch_fall", pc_current, 32'h6);

    do_instr(1,0,0,0, 0,32'hFFFF_FFFF,0, 0,0,0, 0);
    do_instr(0,0,0,0, 0,0,0, 0,0,0, 0);
    chk("pc_wrap", pc_current, 32'h0);

    do_instr(1,1,0,1, 32'h100,32'h40,0, 0,0,0, 0);
    do_instr(1,1,1,1, 32'h7,32'h50,32'h123, 0,1,0, 0);

    do_instr(0,0,0,0, 0,0,0, 0,0,4, 0);

    do_instr(1,0,0,0, 0,32'h8,0, 0,0,0, 0);
    do_instr(0,0,0,0, 0,0,0, 0,0,0, 1);
    chk("epc_nine", epc, 32'h9);

    // reset while waiting in EXECUTE
    scramble();
    fetch_ready = 1'b1;
    #1;
    chk("rx_fetch", 32'(seq_state), 1);
    tick();
    fetch_ready = 1'b0;
    instr_is_branch = 1; instr_is_jump = 0; instr_is_jr = 0;
    tick();
    exec_done = 1'b0;
    #1;
    chk("rx_exec", 32'(seq_state), 3);
    pc_seq_reset = 1'b1;
    tick();
    chk_reset_vals();
    pc_seq_reset = 1'b0;
    tick();
    chk_init_load();

    for (int n = 0; n < 80; n++) begin
      do_instr(1'($urandom), 1'($urandom),
               1'($urandom_range(0, 3) == 0), 1'($urandom),
               $urandom, $urandom, $urandom,
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
